// File: rtl/wb_esc_pad_mux_n.sv
// wb_esc_pad_mux_n: Wishbone-controlled ESC pad mux. Each motor pad is driven
// either by its DSHOT encoder or, for one selected channel, by the serial
// bridge. Route changes tristate all pads for a guard interval.
// Optional macro ESC_MUX_SNIFFER_EN adds an MSP passthrough sniffer that forces
// serial mode, plus an inactivity watchdog that releases it again.
module wb_esc_pad_mux_n #(
    parameter int NUM_CH       = 4,
    parameter int CLK_FREQ_HZ  = 72_000_000,
    parameter int GUARD_CYCLES = 8,
    parameter int WDOG_SEC     = 5,
    localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_stall_o,
    input  logic [7:0]        pc_rx_data,
    input  logic              pc_rx_valid,
    input  logic [NUM_CH-1:0] dshot_in,
    input  logic              serial_tx_i,
    input  logic              serial_oe_i,
    output logic              serial_rx_o,
    inout  wire  [NUM_CH-1:0] pad_motor,
    output logic              mux_sel,
    output logic [CHW-1:0]    mux_ch,
    output logic              msp_mode,
    output logic              guard_busy
);

    localparam logic [9:0] A_CTRL = 10'h100;
    localparam logic [9:0] A_STAT = 10'h101;
    localparam logic [9:0] A_CMD  = 10'h102;

    // ---------------- bus side ----------------
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_reg_sel;
    logic              r_msp;
    logic [CHW-1:0]    r_reg_ch;
    logic [31:0]       w_rdata;
    logic              w_req;
    logic              w_wr;
    logic              w_auto;
    logic [15:0]       w_wd_sec;
    logic              w_unused;

    // A request is taken only while no ack is pending, so ack is a single pulse
    assign w_req      = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr       = w_req & wb_we_i;
    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_dat;
    assign wb_stall_o = 1'b0;
    assign msp_mode   = r_msp;
    assign mux_sel    = r_reg_sel & ~w_auto;
    assign mux_ch     = r_reg_ch;

    // Register read mux; unmapped offsets and CMD read as zero
    always_comb begin
        w_rdata = '0;
        case (wb_adr_i[11:2])
            A_CTRL: begin
                w_rdata[0]       = r_reg_sel;
                w_rdata[1]       = r_msp;
                w_rdata[CHW+7:8] = r_reg_ch;
            end
            A_STAT: begin
                w_rdata[0]       = w_auto;
                w_rdata[1]       = guard_busy;
                w_rdata[2]       = mux_sel;
                w_rdata[CHW+7:8] = mux_ch;
                w_rdata[31:16]   = w_wd_sec;
            end
            A_CMD:   w_rdata = '0;
            default: w_rdata = '0;
        endcase
    end

    // Ack and read data are registered together, one cycle after the request
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wb_we_i) ? w_rdata : '0;
        end
    end

    // CTRL register; an out-of-range channel (full byte compared) keeps the old one
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_reg_sel <= 1'b1;
            r_msp     <= 1'b0;
            r_reg_ch  <= '0;
        end else if (w_wr && wb_adr_i[11:2] == A_CTRL) begin
            r_reg_sel <= wb_dat_i[0];
            r_msp     <= wb_dat_i[1];
            if (int'(wb_dat_i[15:8]) < NUM_CH)
                r_reg_ch <= wb_dat_i[CHW+7:8];
        end
    end

`ifdef ESC_MUX_SNIFFER_EN
    // ---------------- MSP sniffer + watchdog ----------------
    localparam int WCW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_DOLLAR, S_M, S_ARROW, S_SIZE} sniff_t;
    sniff_t          r_sn;
    sniff_t          w_sn_nxt;
    logic            w_match;
    logic            w_cmd_clr;
    logic            w_wd_exp;
    logic            r_auto;
    logic [WCW-1:0]  r_wd_cyc;
    logic [15:0]     r_wd_sec;

    assign w_cmd_clr = w_wr && (wb_adr_i[11:2] == A_CMD) && wb_dat_i[0];
    assign w_auto    = r_auto;
    assign w_wd_sec  = r_wd_sec;
    // Total elapsed = sec*CLK_FREQ_HZ + cyc; expire at CLK_FREQ_HZ*WDOG_SEC-1
    assign w_wd_exp  = r_auto && (r_wd_cyc == WCW'(CLK_FREQ_HZ - 1))
                              && (r_wd_sec == 16'(WDOG_SEC - 1));

    // Sniffer state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_sn <= S_IDLE;
        else          r_sn <= w_sn_nxt;
    end

    // Sniffer next state: match "$M<" then size, then passthrough command byte
    always_comb begin
        w_sn_nxt = r_sn;
        w_match  = 1'b0;
        if (pc_rx_valid) begin
            case (r_sn)
                S_IDLE:   if (pc_rx_data == 8'h24) w_sn_nxt = S_DOLLAR;
                S_DOLLAR: w_sn_nxt = (pc_rx_data == 8'h4D) ? S_M : S_IDLE;
                S_M:      w_sn_nxt = (pc_rx_data == 8'h3C) ? S_ARROW : S_IDLE;
                S_ARROW:  w_sn_nxt = S_SIZE;
                S_SIZE: begin
                    w_sn_nxt = S_IDLE;
                    w_match  = (pc_rx_data == 8'hF5) || (pc_rx_data == 8'h64);
                end
                default:  w_sn_nxt = S_IDLE;
            endcase
        end
    end

    // auto_active (CMD clear beats a match) and the seconds/cycles watchdog
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_auto   <= 1'b0;
            r_wd_cyc <= '0;
            r_wd_sec <= '0;
        end else begin
            if (w_cmd_clr)     r_auto <= 1'b0;
            else if (w_match)  r_auto <= 1'b1;
            else if (w_wd_exp) r_auto <= 1'b0;

            if (!r_auto || pc_rx_valid || w_wd_exp) begin
                r_wd_cyc <= '0;
                r_wd_sec <= '0;
            end else if (r_wd_cyc == WCW'(CLK_FREQ_HZ - 1)) begin
                r_wd_cyc <= '0;
                if (r_wd_sec != 16'hFFFF) r_wd_sec <= r_wd_sec + 16'd1;
            end else begin
                r_wd_cyc <= r_wd_cyc + 1'b1;
            end
        end
    end

    assign w_unused = ^{wb_sel_i, wb_adr_i[31:12], wb_adr_i[1:0],
                        wb_dat_i[31:16], wb_dat_i[7:2]};
`else
    assign w_auto   = 1'b0;
    assign w_wd_sec = '0;
    assign w_unused = ^{wb_sel_i, wb_adr_i[31:12], wb_adr_i[1:0],
                        wb_dat_i[31:16], wb_dat_i[7:2], pc_rx_data, pc_rx_valid};
`endif

    // ---------------- route-change guard ----------------
    typedef enum logic {G_RUN = 1'b0, G_GUARD = 1'b1} guard_t;
    guard_t          r_gst;
    guard_t          w_gst_nxt;
    logic            r_prev_sel;
    logic [CHW-1:0]  r_prev_ch;
    logic [7:0]      r_gcnt;
    logic            w_route_chg;
    logic            w_load;

    assign w_route_chg = (mux_sel != r_prev_sel) || (mux_ch != r_prev_ch);
    assign guard_busy  = (r_gst == G_GUARD);

    // Guard state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_gst <= G_RUN;
        else          r_gst <= w_gst_nxt;
    end

    // Guard next state; any route change (re)starts the full interval
    always_comb begin
        w_gst_nxt = r_gst;
        w_load    = 1'b0;
        case (r_gst)
            G_RUN: begin
                if (w_route_chg) begin
                    w_gst_nxt = G_GUARD;
                    w_load    = 1'b1;
                end
            end
            G_GUARD: begin
                if (w_route_chg)         w_load    = 1'b1;
                else if (r_gcnt == 8'd0) w_gst_nxt = G_RUN;
            end
            default: w_gst_nxt = G_RUN;
        endcase
    end

    // Latched route and guard down-counter
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_prev_sel <= 1'b1;
            r_prev_ch  <= '0;
            r_gcnt     <= '0;
        end else if (w_load) begin
            r_prev_sel <= mux_sel;
            r_prev_ch  <= mux_ch;
            r_gcnt     <= 8'(GUARD_CYCLES - 1);
        end else if (r_gst == G_GUARD && r_gcnt != 8'd0) begin
            r_gcnt <= r_gcnt - 8'd1;
        end
    end

    // ---------------- pad drive ----------------
    logic [NUM_CH-1:0] r_dshot;
    logic              r_tx;
    logic              r_soe;
    logic [NUM_CH-1:0] r_pad_o;
    logic [NUM_CH-1:0] r_pad_oe;
    logic [NUM_CH-1:0] w_pad_o;
    logic [NUM_CH-1:0] w_pad_oe;
    logic              r_sync1;
    logic              r_sync2;

    // Per-pad source select from the registered inputs
    always_comb begin
        w_pad_o  = '0;
        w_pad_oe = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mux_sel) begin
                w_pad_o[i]  = r_dshot[i];
                w_pad_oe[i] = 1'b1;
            end else if (mux_ch == CHW'(i)) begin
                w_pad_o[i]  = r_tx;
                w_pad_oe[i] = r_soe;
            end
        end
    end

    // Input capture, then registered pad outputs (one cycle behind the inputs)
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dshot  <= '0;
            r_tx     <= 1'b0;
            r_soe    <= 1'b0;
            r_pad_o  <= '0;
            r_pad_oe <= '0;
        end else begin
            r_dshot  <= dshot_in;
            r_tx     <= serial_tx_i;
            r_soe    <= serial_oe_i;
            r_pad_o  <= w_pad_o;
            r_pad_oe <= w_pad_oe;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pad
        assign pad_motor[g] = (r_pad_oe[g] && !guard_busy) ? r_pad_o[g] : 1'bz;
    end

    // Two-flop synchroniser of the selected pad for the bridge RX line
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= pad_motor[mux_ch];
            r_sync2 <= r_sync1;
        end
    end

    assign serial_rx_o = (!mux_sel && !guard_busy) ? r_sync2 : 1'b1;

endmodule

// File: tb/tb_wb_esc_pad_mux_n.sv
// Self-checking bench for wb_esc_pad_mux_n (NUM_CH=8, GUARD_CYCLES=8,
// CLK_FREQ_HZ=100, WDOG_SEC=5). Register accesses come from a vector table;
// read expectations travel through a scoreboard queue until the ack.
module tb_wb_esc_pad_mux_n;
    localparam int NCH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic        wb_we  = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic [7:0]  pc_rx_data = '0;
    logic        pc_rx_valid = 1'b0;
    logic [NCH-1:0] dshot_in = '0;
    logic        serial_tx = 1'b0;
    logic        serial_oe = 1'b0;
    logic        serial_rx_o;
    wire  [NCH-1:0] pad_motor;
    logic        mux_sel;
    logic [2:0]  mux_ch;
    logic        msp_mode;
    logic        guard_busy;

    always #5 clk = ~clk;

    wb_esc_pad_mux_n #(
        .NUM_CH(NCH), .CLK_FREQ_HZ(100), .GUARD_CYCLES(8), .WDOG_SEC(5)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
        .wb_we_i(wb_we), .wb_sel_i(4'hF), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
        .pc_rx_data(pc_rx_data), .pc_rx_valid(pc_rx_valid), .dshot_in(dshot_in),
        .serial_tx_i(serial_tx), .serial_oe_i(serial_oe), .serial_rx_o(serial_rx_o),
        .pad_motor(pad_motor), .mux_sel(mux_sel), .mux_ch(mux_ch),
        .msp_mode(msp_mode), .guard_busy(guard_busy)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic        we;
        logic [9:0]  off;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic        exp_msp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ra(input logic [9:0] off);
        return {20'd0, off, 2'b00};
    endfunction

    // One Wishbone transfer; read expectations go through the scoreboard
    task automatic wb_xfer(input logic we, input logic [9:0] off,
                           input logic [31:0] dat, input logic [31:0] exp_rd);
        int n;
        logic [31:0] e;
        @(negedge clk);
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = we; wb_adr = ra(off); wb_dat = dat;
        if (!we) sb_q.push_back(exp_rd);
        n = 0;
        do begin @(negedge clk); n++; end while (!wb_ack_o && n < 8);
        check("ack_latency", n, 1);
        if (!we) begin
            e = sb_q.pop_front();
            if (wb_ack_o) check("rd_data", wb_dat_o, e);
        end
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!guard_busy && n < 6) begin @(negedge clk); n++; end
        check(name, guard_busy, 1'b1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (guard_busy && n < 40) begin n++; @(negedge clk); end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); pc_rx_data = b; pc_rx_valid = 1'b1;
        @(negedge clk); pc_rx_valid = 1'b0;
    endtask

    task automatic send_msp();
        send_byte(8'h24); send_byte(8'h4D); send_byte(8'h3C);
        send_byte(8'h00); send_byte(8'hF5);
    endtask

    initial begin
        int n;
        logic [NCH-1:0] pats[4];
        logic [NCH-1:0] prev;

        vecs[0]  = '{1'b0, 10'h100, 32'h0,        32'h0000_0001, 1'b0};
        vecs[1]  = '{1'b0, 10'h101, 32'h0,        32'h0000_0004, 1'b0};
        vecs[2]  = '{1'b0, 10'h102, 32'h0,        32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 10'h000, 32'h0,        32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 10'h3FF, 32'hFFFF_FFFF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 10'h3FF, 32'h0,        32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 10'h100, 32'h0000_0303, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 10'h100, 32'h0,        32'h0000_0303, 1'b1};
        vecs[8]  = '{1'b1, 10'h100, 32'h0000_0901, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 10'h100, 32'h0,        32'h0000_0301, 1'b0};
        vecs[10] = '{1'b1, 10'h100, 32'h0000_0001, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 10'h100, 32'h0,        32'h0000_0001, 1'b0};
        pats = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_stall", wb_stall_o, 1'b0);
        check("rst_guard", guard_busy, 1'b0);
        check("rst_mux_sel", mux_sel, 1'b1);
        check("rst_mux_ch", mux_ch, 3'd0);
        check("rst_msp", msp_mode, 1'b0);
        check("rst_rx", serial_rx_o, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // DSHOT passthrough: pads change two edges after dshot_in
        prev = '0;
        foreach (pats[k]) begin
            dshot_in = pats[k];
            @(negedge clk);
            check("dshot_hold", pad_motor, prev);
            @(negedge clk);
            check("dshot_follow", pad_motor, pats[k]);
            prev = pats[k];
        end

        // register table
        for (int i = 0; i < 12; i++) begin
            wb_xfer(vecs[i].we, vecs[i].off, vecs[i].dat, vecs[i].exp_rd);
            check("msp_mode", msp_mode, vecs[i].exp_msp);
        end
        repeat (12) @(negedge clk);

        // ack is a single pulse even if stb stays high
        @(negedge clk); wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = ra(10'h100);
        @(negedge clk);
        check("ack_pulse_hi", wb_ack_o, 1'b1);
        @(negedge clk);
        check("ack_pulse_lo", wb_ack_o, 1'b0);
        wb_stb = 1'b0; wb_cyc = 1'b0;

        // serial route to pad 5: 8-cycle guard, then tx on pad5, rx sync
        serial_tx = 1'b1; serial_oe = 1'b1;
        wb_xfer(1'b1, 10'h100, 32'h0000_0500, 32'h0);
        wait_busy("ser_guard_start");
        count_busy(n);
        check("ser_guard_len", n, 8);
        check("ser_pad5_hi", pad_motor[5], 1'b1);
        serial_tx = 1'b0;
        repeat (2) @(negedge clk);
        check("ser_pad5_lo", pad_motor[5], 1'b0);
        @(negedge clk);
        check("ser_rx_lag", serial_rx_o, 1'b1);
        @(negedge clk);
        check("ser_rx_follow", serial_rx_o, 1'b0);
        wb_xfer(1'b0, 10'h101, 32'h0, 32'h0000_0500);

        // channel change in mid-guard restarts the full interval
        serial_tx = 1'b1;
        wb_xfer(1'b1, 10'h100, 32'h0000_0600, 32'h0);
        wait_busy("re_guard_start");
        repeat (3) @(negedge clk);
        wb_xfer(1'b1, 10'h100, 32'h0000_0700, 32'h0);
        check("re_guard_mid", guard_busy, 1'b1);
        @(negedge clk);
        count_busy(n);
        check("re_guard_len", n, 8);
        check("re_pad7", pad_motor[7], 1'b1);

        // sniffer / watchdog / CMD
        wb_xfer(1'b1, 10'h100, 32'h0000_0001, 32'h0);
        repeat (12) @(negedge clk);
`ifdef ESC_MUX_SNIFFER_EN
        send_msp();
        check("snf_mux_sel", mux_sel, 1'b0);
        n = 0;
        while (!mux_sel && n < 1000) begin n++; @(negedge clk); end
        check("wdog_len", n, 500);
        repeat (12) @(negedge clk);
        send_msp();
        repeat (149) @(negedge clk);
        wb_xfer(1'b0, 10'h101, 32'h0, 32'h0001_0001);
        send_byte(8'h55);
        wb_xfer(1'b0, 10'h101, 32'h0, 32'h0000_0001);
        wb_xfer(1'b1, 10'h102, 32'h0000_0001, 32'h0);
        wb_xfer(1'b0, 10'h101, 32'h0, 32'h0000_0006);
        check("cmd_mux_sel", mux_sel, 1'b1);
`else
        send_msp();
        check("nosnf_mux_sel", mux_sel, 1'b1);
        wb_xfer(1'b0, 10'h101, 32'h0, 32'h0000_0004);
        wb_xfer(1'b1, 10'h102, 32'h0000_0001, 32'h0);
        wb_xfer(1'b0, 10'h101, 32'h0, 32'h0000_0004);
`endif
        repeat (12) @(negedge clk);

        // reset in mid-guard with a transfer pending
        wb_xfer(1'b1, 10'h100, 32'h0000_0200, 32'h0);
        wait_busy("pre_rst_guard");
        @(negedge clk);
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = ra(10'h100);
        #1 rst = 1'b1;
        #1;
        check("arst_guard", guard_busy, 1'b0);
        check("arst_mux_sel", mux_sel, 1'b1);
        check("arst_mux_ch", mux_ch, 3'd0);
        @(negedge clk);
        check("arst_no_ack", wb_ack_o, 1'b0);
        wb_stb = 1'b0; wb_cyc = 1'b0; rst = 1'b0;
        @(negedge clk);
        wb_xfer(1'b0, 10'h100, 32'h0, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
